// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ctrl_pkg
// Description : Shared types and default timing for the PWM control front end.
//               Holds the debounce FSM state encoding and the default
//               debounce / auto-repeat timing (100 MHz system clock).
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_ctrl_pkg;

    // Debounce FSM states. The two upper states are the "button held" half,
    // which is what the debounced level output reports.
    typedef enum logic [1:0] {
        IDLE            = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } debounce_state_t;

    // 10 ms debounce window, 500 ms before the first repeat, 200 ms between repeats
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 20_000_000;

endpackage : pwm_ctrl_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One push-button channel: 2-flop synchroniser, debounce FSM
//               with saturating confirm counter, and an unregistered
//               single-cycle press pulse for the parent to register.
//               Optional macro AUTO_REPEAT_EN adds a hold counter that emits
//               extra pulses while the button stays pressed.
// Ports       : clk       - system clock, rising edge
//               rst_n     - asynchronous active-low reset
//               i_btn_raw - raw asynchronous button, active-high
//               o_level   - debounced level (registered FSM state decode)
//               o_pulse   - combinational pulse; high in the cycle before the
//                           accepting (or repeating) clock edge
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import pwm_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_pulse
);

    localparam int               c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DEBOUNCE_CYCLES);

    logic                 r_sync1;
    logic                 r_sync2;
    debounce_state_t      r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic                 w_accept;
    logic                 w_release_done;
    logic                 w_repeat;

    // Saturating increment: the counter must never wrap back into range.
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

    // The edge that would move the count to DEBOUNCE_CYCLES is the accepting edge.
    assign w_accept       = (r_state == CONFIRM_PRESS)   &&  r_sync2 && (r_cnt == c_cnt_last);
    assign w_release_done = (r_state == CONFIRM_RELEASE) && !r_sync2 && (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
            case (r_state)
                IDLE: begin
                    if (r_sync2) begin
                        r_state <= CONFIRM_PRESS;
                        r_cnt   <= c_cnt_w'(1);
                    end
                end
                CONFIRM_PRESS: begin
                    if (!r_sync2) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!r_sync2) begin
                        r_state <= CONFIRM_RELEASE;
                        r_cnt   <= c_cnt_w'(1);
                    end
                end
                CONFIRM_RELEASE: begin
                    if (r_sync2) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (w_release_done) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int c_hold_top = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_hold_w   = $clog2(c_hold_top + 1);

    logic [c_hold_w-1:0] r_hold;
    logic                r_repeating;
    logic                w_hold_hit;

    // Before the first repeat the hold count is compared against the initial
    // delay; afterwards against the repeat period. The count restarts at each hit.
    assign w_hold_hit = (r_state == PRESSED) &&
                        (r_hold == (r_repeating ? c_hold_w'(REPEAT_PERIOD - 1)
                                                : c_hold_w'(REPEAT_DELAY - 1)));

    // Counts only while PRESSED: CONFIRM_RELEASE freezes it so a release
    // glitch resumes the hold where it left off; reaching IDLE clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_repeating <= 1'b0;
        end else if (w_release_done || (r_state == IDLE)) begin
            r_hold      <= '0;
            r_repeating <= 1'b0;
        end else if (r_state == PRESSED) begin
            if (w_hold_hit) begin
                r_hold      <= '0;
                r_repeating <= 1'b1;
            end else begin
                r_hold      <= r_hold + 1'b1;
            end
        end
    end

    assign w_repeat = w_hold_hit;
`else
    assign w_repeat = 1'b0;
`endif

    assign o_level = (r_state == PRESSED) || (r_state == CONFIRM_RELEASE);
    assign o_pulse = w_accept | w_repeat;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/duty_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : duty_button_debouncer
// Description : Turns two raw duty up/down push-buttons into clean,
//               registered, mutually exclusive single-cycle step pulses for
//               the downstream PWM generator.
//               Optional macro AUTO_REPEAT_EN: a held button keeps stepping
//               (first repeat after REPEAT_DELAY, then every REPEAT_PERIOD).
// Ports       : clk           - system clock (100 MHz), rising edge
//               rst_n         - asynchronous active-low reset
//               btn_inc_raw   - raw "duty up" button, active-high
//               btn_dec_raw   - raw "duty down" button, active-high
//               increase_duty - one-cycle pulse per accepted up step
//               decrease_duty - one-cycle pulse per accepted down step
//               inc_level     - debounced up-button level
//               dec_level     - debounced down-button level
// Revision    : 1.0 - initial release
// ============================================================================
module duty_button_debouncer
    import pwm_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    output logic increase_duty,
    output logic decrease_duty,
    output logic inc_level,
    output logic dec_level
);

    logic w_inc_pulse;
    logic w_dec_pulse;
    logic r_increase_duty;
    logic r_decrease_duty;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_inc_channel (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_btn_raw (btn_inc_raw),
        .o_level   (inc_level),
        .o_pulse   (w_inc_pulse)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_dec_channel (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_btn_raw (btn_dec_raw),
        .o_level   (dec_level),
        .o_pulse   (w_dec_pulse)
    );

    // Coinciding up/down steps are ambiguous, so both are dropped; the
    // channel FSMs are unaffected and keep advancing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_increase_duty <= 1'b0;
            r_decrease_duty <= 1'b0;
        end else begin
            r_increase_duty <= w_inc_pulse & ~w_dec_pulse;
            r_decrease_duty <= w_dec_pulse & ~w_inc_pulse;
        end
    end

    assign increase_duty = r_increase_duty;
    assign decrease_duty = r_decrease_duty;

endmodule : duty_button_debouncer
`default_nettype wire
